// File: rtl/scv_pkg.sv
// scv_pkg: shared constants and types for the Super Cassette Vision timing core.
//   - Default raster geometry (pixels per line, lines per frame, sync windows).
//   - Default pixel clock divider.
//   - cp_phase_t: the four uPD7800 clock phases, in sequence order.
package scv_pkg;

    localparam int SCV_CNT_W    = 9;

    localparam int SCV_PIX_DIV  = 2;
    localparam int SCV_H_TOTAL  = 260;
    localparam int SCV_H_ACTIVE = 192;
    localparam int SCV_HS_START = 216;
    localparam int SCV_HS_END   = 236;
    localparam int SCV_V_TOTAL  = 263;
    localparam int SCV_V_ACTIVE = 222;
    localparam int SCV_VS_START = 240;
    localparam int SCV_VS_END   = 243;

    // Encoding equals the strobe index: CP1P->bit0 ... CP2N->bit3.
    typedef enum logic [1:0] {
        CP1P = 2'd0,
        CP1N = 2'd1,
        CP2P = 2'd2,
        CP2N = 2'd3
    } cp_phase_t;

endpackage

// File: rtl/scv_cpclk.sv
// scv_cpclk: uPD7800 phase sequencer.
//   CLK          in  system clock
//   RESETB       in  asynchronous active-low reset
//   CP_HOLD      in  freeze the phase sequence (no strobes while high)
//   CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE
//                out one-cycle registered phase strobes
module scv_cpclk
    import scv_pkg::*;
(
    input  logic CLK,
    input  logic RESETB,
    input  logic CP_HOLD,
    output logic CP1_POSEDGE,
    output logic CP1_NEGEDGE,
    output logic CP2_POSEDGE,
    output logic CP2_NEGEDGE
);

    cp_phase_t  ph_reg, ph_next;
    logic [3:0] strobe_reg, strobe_next;

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            ph_reg     <= CP1P;
            strobe_reg <= 4'b0000;
        end else begin
            ph_reg     <= ph_next;
            strobe_reg <= strobe_next;
        end
    end

    // The strobe emitted is the decode of the phase before it advances, so
    // a held phase is replayed as the first strobe after release.
    always_comb begin
        ph_next     = ph_reg;
        strobe_next = 4'b0000;
        if (!CP_HOLD) begin
            unique case (ph_reg)
                CP1P: begin strobe_next = 4'b0001; ph_next = CP1N; end
                CP1N: begin strobe_next = 4'b0010; ph_next = CP2P; end
                CP2P: begin strobe_next = 4'b0100; ph_next = CP2N; end
                CP2N: begin strobe_next = 4'b1000; ph_next = CP1P; end
                default: begin strobe_next = 4'b0000; ph_next = CP1P; end
            endcase
        end
    end

    assign CP1_POSEDGE = strobe_reg[0];
    assign CP1_NEGEDGE = strobe_reg[1];
    assign CP2_POSEDGE = strobe_reg[2];
    assign CP2_NEGEDGE = strobe_reg[3];

endmodule

// File: rtl/scv_timing.sv
// scv_timing: master timing generator (CPU phase strobes + video raster).
//   CLK, RESETB        in  system clock, asynchronous active-low reset
//   CP_HOLD            in  stall the CPU phase sequence
//   CPx_POSEDGE/NEGEDGE out one-cycle phase strobes to upd7800
//   PIX_CE             out pixel clock enable (registered, one CLK wide)
//   HCNT, VCNT         out current pixel / line
//   HBLANK, VBLANK, HSYNC, VSYNC out registered raster decodes
//   FRAME_START        out pulse on the PIX_CE showing HCNT=0, VCNT=0
//   INT2               out vertical-blank interrupt level (= VBLANK)
module scv_timing
    import scv_pkg::*;
#(
    parameter int PIX_DIV  = SCV_PIX_DIV,
    parameter int H_TOTAL  = SCV_H_TOTAL,
    parameter int H_ACTIVE = SCV_H_ACTIVE,
    parameter int HS_START = SCV_HS_START,
    parameter int HS_END   = SCV_HS_END,
    parameter int V_TOTAL  = SCV_V_TOTAL,
    parameter int V_ACTIVE = SCV_V_ACTIVE,
    parameter int VS_START = SCV_VS_START,
    parameter int VS_END   = SCV_VS_END
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       CP_HOLD,
    output logic       CP1_POSEDGE,
    output logic       CP1_NEGEDGE,
    output logic       CP2_POSEDGE,
    output logic       CP2_NEGEDGE,
    output logic       PIX_CE,
    output logic [8:0] HCNT,
    output logic [8:0] VCNT,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FRAME_START,
    output logic       INT2
);

    generate
        if (PIX_DIV < 1 || PIX_DIV >= 512 || H_TOTAL < 1 || H_TOTAL >= 512 ||
            H_ACTIVE >= 512 || HS_START >= 512 || HS_END >= 512 ||
            V_TOTAL < 1 || V_TOTAL >= 512 || V_ACTIVE >= 512 ||
            VS_START >= 512 || VS_END >= 512) begin : g_param_err
            $error("scv_timing: parameters must fit 9-bit unsigned counters");
        end
    endgenerate

    localparam logic [8:0] DIV_LAST = 9'(PIX_DIV - 1);
    localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
    localparam logic [8:0] HS_S     = 9'(HS_START);
    localparam logic [8:0] HS_E     = 9'(HS_END);
    localparam logic [8:0] VS_S     = 9'(VS_START);
    localparam logic [8:0] VS_E     = 9'(VS_END);

    scv_cpclk u_cpclk (
        .CLK         (CLK),
        .RESETB      (RESETB),
        .CP_HOLD     (CP_HOLD),
        .CP1_POSEDGE (CP1_POSEDGE),
        .CP1_NEGEDGE (CP1_NEGEDGE),
        .CP2_POSEDGE (CP2_POSEDGE),
        .CP2_NEGEDGE (CP2_NEGEDGE)
    );

    logic [8:0] div_reg, div_next;
    logic [8:0] hcnt_reg, hcnt_next;
    logic [8:0] vcnt_reg, vcnt_next;
    logic       pix_ce_reg;
    logic       hblank_reg, vblank_reg, hsync_reg, vsync_reg;
    logic       frame_start_reg;

    always_comb begin
        div_next  = (div_reg == DIV_LAST) ? 9'd0 : div_reg + 9'd1;
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        if (pix_ce_reg) begin
            if (hcnt_reg == H_LAST) begin
                hcnt_next = 9'd0;
                vcnt_next = (vcnt_reg == V_LAST) ? 9'd0 : vcnt_reg + 9'd1;
            end else begin
                hcnt_next = hcnt_reg + 9'd1;
            end
        end
    end

    // PIX_CE is registered so it is 0 throughout reset even when PIX_DIV=1;
    // the first enable therefore lands PIX_DIV edges after release. Decodes
    // are taken from the next counter values so they flip on the same edge
    // as the counters they describe.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            div_reg         <= 9'd0;
            pix_ce_reg      <= 1'b0;
            hcnt_reg        <= 9'd0;
            vcnt_reg        <= 9'd0;
            hblank_reg      <= 1'b0;
            vblank_reg      <= 1'b0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            div_reg         <= div_next;
            pix_ce_reg      <= (div_reg == DIV_LAST);
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            hblank_reg      <= (hcnt_next >= H_ACT);
            vblank_reg      <= (vcnt_next >= V_ACT);
            hsync_reg       <= (hcnt_next >= HS_S) && (hcnt_next < HS_E);
            vsync_reg       <= (vcnt_next >= VS_S) && (vcnt_next < VS_E);
            frame_start_reg <= (div_reg == DIV_LAST) &&
                               (hcnt_next == 9'd0) && (vcnt_next == 9'd0);
        end
    end

    assign PIX_CE      = pix_ce_reg;
    assign HCNT        = hcnt_reg;
    assign VCNT        = vcnt_reg;
    assign HBLANK      = hblank_reg;
    assign VBLANK      = vblank_reg;
    assign HSYNC       = hsync_reg;
    assign VSYNC       = vsync_reg;
    assign FRAME_START = frame_start_reg;
    assign INT2        = vblank_reg;

endmodule

// File: tb/tb_scv_timing.sv
// tb_scv_timing: self-checking bench for scv_timing.
// A reduced-geometry instance (dut) exercises frame, blanking and sync
// timing within a short run; a second instance (dut1) uses the default
// geometry with PIX_DIV=1. Expected values come from a cycle-count model:
// t = CLK edges since reset release, pixel index n = (t-1)/PIX_DIV.
module tb_scv_timing;

    localparam int D   = 2;
    localparam int H   = 26;
    localparam int HA  = 19;
    localparam int HSS = 21;
    localparam int HSE = 23;
    localparam int V   = 20;
    localparam int VA  = 15;
    localparam int VSS = 16;
    localparam int VSE = 18;
    localparam int F   = H * V * D;

    localparam int H1  = 260;
    localparam int HA1 = 192;
    localparam int V1  = 263;

    logic       CLK = 1'b0;
    logic       RESETB = 1'b0;
    logic       CP_HOLD = 1'b0;

    logic       cp1p, cp1n, cp2p, cp2n, pix_ce;
    logic [8:0] hcnt, vcnt;
    logic       hblank, vblank, hsync, vsync, frame_start, int2;

    logic       cp1p_1, cp1n_1, cp2p_1, cp2n_1, pix_ce_1;
    logic [8:0] hcnt_1, vcnt_1;
    logic       hblank_1, vblank_1, hsync_1, vsync_1, frame_start_1, int2_1;

    scv_timing #(
        .PIX_DIV(D), .H_TOTAL(H), .H_ACTIVE(HA), .HS_START(HSS), .HS_END(HSE),
        .V_TOTAL(V), .V_ACTIVE(VA), .VS_START(VSS), .VS_END(VSE)
    ) dut (
        .CLK(CLK), .RESETB(RESETB), .CP_HOLD(CP_HOLD),
        .CP1_POSEDGE(cp1p), .CP1_NEGEDGE(cp1n),
        .CP2_POSEDGE(cp2p), .CP2_NEGEDGE(cp2n),
        .PIX_CE(pix_ce), .HCNT(hcnt), .VCNT(vcnt),
        .HBLANK(hblank), .VBLANK(vblank), .HSYNC(hsync), .VSYNC(vsync),
        .FRAME_START(frame_start), .INT2(int2)
    );

    scv_timing #(.PIX_DIV(1)) dut1 (
        .CLK(CLK), .RESETB(RESETB), .CP_HOLD(CP_HOLD),
        .CP1_POSEDGE(cp1p_1), .CP1_NEGEDGE(cp1n_1),
        .CP2_POSEDGE(cp2p_1), .CP2_NEGEDGE(cp2n_1),
        .PIX_CE(pix_ce_1), .HCNT(hcnt_1), .VCNT(vcnt_1),
        .HBLANK(hblank_1), .VBLANK(vblank_1), .HSYNC(hsync_1), .VSYNC(vsync_1),
        .FRAME_START(frame_start_1), .INT2(int2_1)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;

    int t = 0;              // edges since reset release
    int c = 0;              // non-held edges since reset release
    int exp_strobe = 0;     // expected {CP2N,CP2P,CP1N,CP1P}

    int last_fs = -1;
    int vb_cnt = 0, hs_cnt = 0, vs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic check_all();
        int n, h, v, n1, h1, v1;
        logic pce, pce1, fs, vb;
        n   = (t >= 1) ? (t - 1) / D : 0;
        h   = n % H;
        v   = (n / H) % V;
        pce = (t >= 1) && (t % D == 0);
        fs  = pce && (n % (H * V) == 0);
        vb  = (v >= VA);
        chk("strobes", {cp2n, cp2p, cp1n, cp1p}, exp_strobe);
        chk("pix_ce", pix_ce, pce);
        chk("hcnt", hcnt, h);
        chk("vcnt", vcnt, v);
        chk("hblank", hblank, h >= HA);
        chk("vblank", vblank, vb);
        chk("int2", int2, vb);
        chk("hsync", hsync, (h >= HSS) && (h < HSE));
        chk("vsync", vsync, (v >= VSS) && (v < VSE));
        chk("frame_start", frame_start, fs);
        n1   = (t >= 1) ? t - 1 : 0;
        h1   = n1 % H1;
        v1   = (n1 / H1) % V1;
        pce1 = (t >= 1);
        chk("strobes_1", {cp2n_1, cp2p_1, cp1n_1, cp1p_1}, exp_strobe);
        chk("pix_ce_1", pix_ce_1, pce1);
        chk("hcnt_1", hcnt_1, h1);
        chk("vcnt_1", vcnt_1, v1);
        chk("hblank_1", hblank_1, h1 >= HA1);
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // check 1 time unit later and update the per-frame measurements.
    task automatic step();
        @(posedge CLK);
        if (!RESETB) begin
            t = 0;
            c = 0;
            exp_strobe = 0;
        end else begin
            t++;
            if (CP_HOLD) begin
                exp_strobe = 0;
            end else begin
                exp_strobe = 1 << (c % 4);
                c++;
            end
        end
        #1;
        check_all();
        if (frame_start) begin
            if (last_fs >= 0) begin
                chk("frame_period", t - last_fs, F);
                chk("vblank_clks", vb_cnt, (V - VA) * H * D);
                chk("hsync_pix", hs_cnt, (HSE - HSS) * V);
                chk("vsync_clks", vs_cnt, (VSE - VSS) * H * D);
                $display("frame t=%0d period=%0d vblank=%0d hsync_pix=%0d vsync=%0d",
                         t, t - last_fs, vb_cnt, hs_cnt, vs_cnt);
            end
            last_fs = t;
            vb_cnt = 0;
            hs_cnt = 0;
            vs_cnt = 0;
        end
        if (vblank) vb_cnt++;
        if (vsync) vs_cnt++;
        if (hsync && pix_ce) hs_cnt++;
    endtask

    initial begin
        // Reset held: everything must stay at zero across edges.
        repeat (3) step();

        // Release between edges; the first edge after release gives CP1P.
        RESETB = 1'b1;
        $display("reset released");
        for (int i = 0; i < 8; i++) begin
            step();
            $display("cycle t=%0d strobes=%b", t, {cp2n, cp2p, cp1n, cp1p});
        end
        // Now just past CP2N; run to CP1N, then hold for 5 edges.
        step();
        step();
        chk("pre_hold_cp1n", cp1n, 1'b1);
        CP_HOLD = 1'b1;
        repeat (5) step();
        CP_HOLD = 1'b0;
        step();
        chk("post_hold_cp2p", cp2p, 1'b1);
        $display("hold released t=%0d strobes=%b", t, {cp2n, cp2p, cp1n, cp1p});

        // Random phase stalls across three reduced frames.
        while (t < 3 * F + 100) begin
            CP_HOLD = ($urandom_range(0, 3) == 0);
            step();
        end
        CP_HOLD = 1'b0;

        // Asynchronous reset mid-frame, away from any clock edge.
        while (((((t - 1) / D) / H) % V) != 10) step();
        #2;
        RESETB = 1'b0;
        t = 0;
        c = 0;
        exp_strobe = 0;
        #1;
        check_all();
        $display("async reset asserted at line 10, outputs checked");
        repeat (2) step();
        RESETB = 1'b1;
        last_fs = -1;
        vb_cnt = 0;
        hs_cnt = 0;
        vs_cnt = 0;
        for (int i = 0; i < F + 80; i++) begin
            CP_HOLD = ($urandom_range(0, 4) == 0);
            step();
        end
        CP_HOLD = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
